cfg_chain_loader: RTL and testbench

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_pkg.sv | 17 +
 rtl/crc16_serial.sv | 24 ++
 rtl/cfg_chain_loader.sv | 137 +++++++++++++
 tb/tb_cfg_chain_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration chain loader.
package cfg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit of CRC-16-CCITT, MSB first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 register: re-seeded by i_init, advanced by one bit when i_en.
module crc16_serial
  import cfg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // CRC state: seed on reset/init, otherwise fold in one bit per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_crc <= CRC16_INIT;
    else if (i_init) r_crc <= CRC16_INIT;
    else if (i_en)   r_crc <= crc16_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams host words MSB-first into a serial configuration chain, tracking
// CRCs of the driven and returned bit streams.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_BITS = 1024,
  parameter int WORD_W     = 32
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              chain_prog_in,
  output logic              chain_prog_en,
  input  logic              chain_prog_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       load_crc,
  output logic [15:0]       rb_crc
);

  localparam int CW = $clog2(CHAIN_BITS + 1);
  localparam int BW = $clog2(WORD_W + 1);

  state_t            r_state;
  logic [CW-1:0]     r_bit_cnt;   // bits already presented (completed enabled cycles)
  logic [WORD_W-1:0] r_buf;       // bits still to present, MSB next
  logic [BW-1:0]     r_buf_cnt;   // number of valid bits left in r_buf
  logic              r_prog_in;
  logic              r_prog_en;
  logic              r_done;
  logic              r_aborted;

  logic [16:0]       w_owed;
  logic [BW-1:0]     w_take;
  logic              w_last;
  logic              w_accept;
  logic              w_start;

  // Bits not yet committed to the output: the bit on the pins this cycle is
  // already committed, and the buffer is empty whenever a word can be taken.
  assign w_owed   = 17'(CHAIN_BITS) - 17'(r_bit_cnt) - 17'(r_prog_en);
  assign w_take   = (w_owed >= 17'(WORD_W)) ? BW'(WORD_W) : w_owed[BW-1:0];
  assign w_last   = r_prog_en && (r_bit_cnt == CW'(CHAIN_BITS - 1));
  assign w_start  = start && (r_state == ST_IDLE);

  // Ready while the final buffered bit is on the pins gives back-to-back words.
  assign word_ready = (r_state == ST_LOAD) && (w_owed != 17'd0) &&
                      (r_buf_cnt == '0) && !abort;
  assign w_accept   = word_valid && word_ready;

  // Load FSM with registered chain drive and status pulses.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_buf     <= '0;
      r_buf_cnt <= '0;
      r_prog_in <= 1'b0;
      r_prog_en <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_prog_en <= 1'b0;
          if (start) begin
            r_state   <= ST_LOAD;
            r_bit_cnt <= '0;
            r_buf     <= '0;
            r_buf_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (r_prog_en) r_bit_cnt <= r_bit_cnt + CW'(1);
          if (abort) begin
            r_state   <= ST_IDLE;
            r_prog_en <= 1'b0;
            r_buf_cnt <= '0;
            r_aborted <= 1'b1;
          end else if (w_last) begin
            r_state   <= ST_IDLE;
            r_prog_en <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_accept) begin
            // Trailing bits beyond the chain length are counted out via w_take.
            r_prog_in <= word_data[WORD_W-1];
            r_buf     <= word_data << 1;
            r_buf_cnt <= w_take - BW'(1);
            r_prog_en <= 1'b1;
          end else if (r_buf_cnt != '0) begin
            r_prog_in <= r_buf[WORD_W-1];
            r_buf     <= r_buf << 1;
            r_buf_cnt <= r_buf_cnt - BW'(1);
            r_prog_en <= 1'b1;
          end else begin
            r_prog_en <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Driven-stream CRC: the bit on chain_prog_in in each enabled cycle.
  crc16_serial u_load_crc (
    .i_clk   (prog_clk),
    .i_rst_n (prog_rst_n),
    .i_init  (w_start),
    .i_en    (r_prog_en),
    .i_bit   (r_prog_in),
    .o_crc   (load_crc)
  );

  // Readback CRC: the chain tail sampled in the same enabled cycle.
  crc16_serial u_rb_crc (
    .i_clk   (prog_clk),
    .i_rst_n (prog_rst_n),
    .i_init  (w_start),
    .i_en    (r_prog_en),
    .i_bit   (chain_prog_out),
    .o_crc   (rb_crc)
  );

  assign chain_prog_in = r_prog_in;
  assign chain_prog_en = r_prog_en;
  assign busy          = (r_state == ST_LOAD);
  assign done          = r_done;
  assign aborted       = r_aborted;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench: instance 0 is a 64-bit chain with a shift-register chain
// model on its tail, instance 1 is a 40-bit chain with a grounded tail.
module tb_cfg_chain_loader;

  logic        prog_clk = 1'b0;
  logic        prog_rst_n;
  logic [1:0]  st, ab, vl, rdy, pin, pen, cpo, bsy, dn, abt;
  logic [31:0] wd [2];
  logic [15:0] lcrc [2];
  logic [15:0] rcrc [2];

  localparam logic [31:0] W1 = 32'hA5A5_0F0F;
  localparam logic [31:0] W2 = 32'h1234_5678;

  int n_chk = 0;
  int n_pass = 0;

  always #5 prog_clk = ~prog_clk;

  cfg_chain_loader #(.CHAIN_BITS(64), .WORD_W(32)) u0 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(st[0]), .abort(ab[0]),
    .word_valid(vl[0]), .word_data(wd[0]), .word_ready(rdy[0]),
    .chain_prog_in(pin[0]), .chain_prog_en(pen[0]), .chain_prog_out(cpo[0]),
    .busy(bsy[0]), .done(dn[0]), .aborted(abt[0]), .load_crc(lcrc[0]), .rb_crc(rcrc[0])
  );

  cfg_chain_loader #(.CHAIN_BITS(40), .WORD_W(32)) u1 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(st[1]), .abort(ab[1]),
    .word_valid(vl[1]), .word_data(wd[1]), .word_ready(rdy[1]),
    .chain_prog_in(pin[1]), .chain_prog_en(pen[1]), .chain_prog_out(cpo[1]),
    .busy(bsy[1]), .done(dn[1]), .aborted(abt[1]), .load_crc(lcrc[1]), .rb_crc(rcrc[1])
  );

  // 64-bit scan chain model behind instance 0
  logic [63:0] chain = '0;
  always @(posedge prog_clk) if (pen[0]) chain <= {chain[62:0], pin[0]};
  assign cpo[0] = chain[63];
  assign cpo[1] = 1'b0;

  // Cycle stamp and negedge monitor
  int   cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  logic q0 [$];
  int   qc0 [$];
  logic q1 [$];
  int   en_cnt1 = 0, rdy_cnt1 = 0, hold_err = 0;
  int   dn_cnt [2] = '{0, 0};
  int   ab_cnt [2] = '{0, 0};
  int   dn_cyc0 = 0;
  logic prev_in0 = 1'b0, prev_rst = 1'b0;

  always @(negedge prog_clk) begin
    if (pen[0]) begin q0.push_back(pin[0]); qc0.push_back(cyc); end
    if (pen[1]) begin q1.push_back(pin[1]); en_cnt1++; end
    if (rdy[1]) rdy_cnt1++;
    for (int u = 0; u < 2; u++) begin
      if (dn[u])  dn_cnt[u]++;
      if (abt[u]) ab_cnt[u]++;
    end
    if (dn[0]) dn_cyc0 = cyc;
    if (prog_rst_n && prev_rst && !pen[0] && pin[0] !== prev_in0) hold_err++;
    prev_in0 = pin[0];
    prev_rst = prog_rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      logic fb = c[15] ^ bits[63-i];
      c = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic step();
    @(posedge prog_clk); #1;
  endtask

  task automatic start_ld(input int u);
    st[u] = 1'b1; step(); st[u] = 1'b0;
  endtask

  task automatic send(input int u, input logic [31:0] w);
    int k = 0;
    vl[u] = 1'b1; wd[u] = w;
    while (!rdy[u] && k < 100) begin step(); k++; end
    if (k >= 100) chk("send_timeout", 32'd0, 32'd1);
    step();
    vl[u] = 1'b0;
  endtask

  task automatic wait_ready(input int u);
    int k = 0;
    while (!rdy[u] && k < 100) begin step(); k++; end
    if (k >= 100) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int u);
    int k = 0;
    while (bsy[u] && k < 300) begin step(); k++; end
    if (k >= 300) chk("idle_timeout", 32'd0, 32'd1);
    step();  // let the monitor log the done/abort cycle
  endtask

  task automatic check_run0(input string tag, input int bq, input int bd, input int span);
    logic [63:0] got = '0;
    chk({tag, "_nbits"}, q0.size() - bq, 64);
    if (q0.size() >= bq + 64) begin
      for (int i = 0; i < 64; i++) got[63-i] = q0[bq+i];
      chk({tag, "_bits_hi"}, got[63:32], W1);
      chk({tag, "_bits_lo"}, got[31:0], W2);
      chk({tag, "_span"}, qc0[bq+63] - qc0[bq], span);
      chk({tag, "_done_lat"}, dn_cyc0 - qc0[bq+63], 1);
    end
    chk({tag, "_done_cnt"}, dn_cnt[0] - bd, 1);
    chk({tag, "_load_crc"}, lcrc[0], crc_ref({W1, W2}, 64));
  endtask

  initial begin
    int bq, bd, ba, br;
    prog_rst_n = 1'b0;
    st = '0; ab = '0; vl = '0; wd[0] = '0; wd[1] = '0;
    repeat (3) step();

    // Reset values
    chk("rst_ready", rdy[0], 0);
    chk("rst_prog_in", pin[0], 0);
    chk("rst_prog_en", pen[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_aborted", abt[0], 0);
    chk("rst_load_crc", lcrc[0], 16'hFFFF);
    chk("rst_rb_crc", rcrc[0], 16'hFFFF);
    prog_rst_n = 1'b1;
    step();

    // Abort in IDLE is ignored
    ba = ab_cnt[0];
    ab[0] = 1'b1; step(); ab[0] = 1'b0; step(); step();
    chk("idle_abort", ab_cnt[0] - ba, 0);
    chk("idle_abort_busy", bsy[0], 0);

    // Back-to-back words into the empty chain
    bq = q0.size(); bd = dn_cnt[0];
    start_ld(0);
    chk("load_busy", bsy[0], 1);
    send(0, W1); send(0, W2);
    wait_idle(0);
    check_run0("b2b", bq, bd, 63);
    chk("b2b_rb_crc", rcrc[0], crc_ref(64'h0, 64));

    // Second identical pass with a stray start mid-stream; readback = pass 1
    bq = q0.size(); bd = dn_cnt[0];
    start_ld(0);
    send(0, W1);
    repeat (3) step();
    st[0] = 1'b1; step(); st[0] = 1'b0;
    send(0, W2);
    wait_idle(0);
    check_run0("rep", bq, bd, 63);
    chk("rep_rb_crc", rcrc[0], crc_ref({W1, W2}, 64));
    step();
    chk("crc_hold", lcrc[0], crc_ref({W1, W2}, 64));

    // Five-cycle word_valid gap mid-stream
    bq = q0.size(); bd = dn_cnt[0];
    start_ld(0);
    send(0, W1);
    wait_ready(0);
    repeat (5) step();
    send(0, W2);
    wait_idle(0);
    check_run0("gap", bq, bd, 68);
    chk("gap_hold", hold_err, 0);

    // 40-bit chain: partial final word, no third word accepted
    bq = q1.size(); bd = dn_cnt[1];
    start_ld(1);
    send(1, W1); send(1, W2);
    br = rdy_cnt1;
    vl[1] = 1'b1; wd[1] = 32'hDEAD_BEEF;
    wait_idle(1);
    repeat (3) step();
    vl[1] = 1'b0;
    chk("c40_nbits", q1.size() - bq, 40);
    if (q1.size() >= bq + 40) begin
      logic [39:0] g = '0;
      for (int i = 0; i < 40; i++) g[39-i] = q1[bq+i];
      chk("c40_bits_hi", g[39:8], W1);
      chk("c40_bits_lo", {24'h0, g[7:0]}, 32'h12);
    end
    chk("c40_no_3rd", rdy_cnt1 - br, 0);
    chk("c40_done_cnt", dn_cnt[1] - bd, 1);
    chk("c40_load_crc", lcrc[1], crc_ref({W1, W2[31:24], 24'h0}, 40));

    // Abort at bit 17
    bq = q0.size(); bd = dn_cnt[0]; ba = ab_cnt[0];
    start_ld(0);
    send(0, W1);
    repeat (17) step();
    chk("abt_en_before", pen[0], 1);
    ab[0] = 1'b1; step(); ab[0] = 1'b0;
    chk("abt_en_after", pen[0], 0);
    chk("abt_pulse", abt[0], 1);
    chk("abt_busy", bsy[0], 0);
    step();
    chk("abt_pulse_end", abt[0], 0);
    step();
    chk("abt_nbits", q0.size() - bq, 18);
    chk("abt_no_done", dn_cnt[0] - bd, 0);
    chk("abt_cnt", ab_cnt[0] - ba, 1);

    // Abort while word_ready is high drops it in the same cycle
    ba = ab_cnt[0];
    start_ld(0);
    send(0, W1);
    wait_ready(0);
    ab[0] = 1'b1;
    #1 chk("abt_ready_drop", rdy[0], 0);
    step(); ab[0] = 1'b0; step();
    chk("abt2_cnt", ab_cnt[0] - ba, 1);

    // Clean reload after abort
    bq = q0.size(); bd = dn_cnt[0];
    start_ld(0);
    send(0, W1); send(0, W2);
    wait_idle(0);
    check_run0("reload", bq, bd, 63);

    // Reset at bit 30
    bd = dn_cnt[0]; ba = ab_cnt[0];
    start_ld(0);
    send(0, W1);
    repeat (30) step();
    prog_rst_n = 1'b0; step();
    chk("mrst_en", pen[0], 0);
    chk("mrst_prog_in", pin[0], 0);
    chk("mrst_ready", rdy[0], 0);
    chk("mrst_busy", bsy[0], 0);
    chk("mrst_done", dn[0], 0);
    chk("mrst_aborted", abt[0], 0);
    chk("mrst_load_crc", lcrc[0], 16'hFFFF);
    chk("mrst_rb_crc", rcrc[0], 16'hFFFF);
    prog_rst_n = 1'b1;
    repeat (3) step();
    chk("mrst_no_pulse", (dn_cnt[0] - bd) + (ab_cnt[0] - ba), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
